// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one full round per clock using externally expanded round keys.
// The FSM walks IDLE -> RUN (rounds 1..10) -> DONE and holds the result until the consumer takes it.
module aes128_encrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key_s1,
    input  logic [127:0] key_s2,
    input  logic [127:0] key_s3,
    input  logic [127:0] key_s4,
    input  logic [127:0] key_s5,
    input  logic [127:0] key_s6,
    input  logic [127:0] key_s7,
    input  logic [127:0] key_s8,
    input  logic [127:0] key_s9,
    input  logic [127:0] key_s10,
    input  logic [127:0] key_s11,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [3:0]   round_cnt
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    // Forward S-box, byte n at bits [8n +: 8] counted from the MSB end
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    fsm_e             fsm_q, fsm_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [7:0]       sb [16];
    logic [7:0]       sr [16];
    logic [7:0]       mc [16];
    logic [BLK_W-1:0] rk;
    logic [BLK_W-1:0] round_out;

    // Round key for the round currently being computed
    always_comb begin
        case (rnd_q)
            4'd1:    rk = key_s2;
            4'd2:    rk = key_s3;
            4'd3:    rk = key_s4;
            4'd4:    rk = key_s5;
            4'd5:    rk = key_s6;
            4'd6:    rk = key_s7;
            4'd7:    rk = key_s8;
            4'd8:    rk = key_s9;
            4'd9:    rk = key_s10;
            4'd10:   rk = key_s11;
            default: rk = '0;
        endcase
    end

    // SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey
    always_comb begin
        round_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state_q[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            round_out[127-8*i -: 8] = ((rnd_q == LAST_RND) ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rnd_d       = rnd_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = plaintext ^ key_s1;
                    rnd_d      = RND_W'(1);
                    in_ready_d = 1'b0;
                    fsm_d      = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                if (rnd_q == LAST_RND) begin
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    rnd_d       = '0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                rnd_d       = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                fsm_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = state_q;
    assign round_cnt  = rnd_q;

endmodule

// File: doc/aes128_encrypt_iter.md
AES128_ENCRYPT_ITER -- requirements
Module: aes128_encrypt_iter

Interface
REQ-001 SHALL have no parameters; AES-128 only, 10 rounds fixed.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  plaintext offered.
REQ-005 SHALL have port: in_ready  output  1  core can accept a block.
REQ-006 SHALL have port: plaintext  input  128  block; byte 0 = [127:120], FIPS-197 column-major.
REQ-007 SHALL have ports: key_s1..key_s11  input  128 each  round keys 0..10, as produced by key_Expansion_128.
REQ-008 SHALL have port: out_valid  output  1  ciphertext available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes ciphertext.
REQ-010 SHALL have port: ciphertext  output  128  result, same byte ordering as plaintext.
REQ-011 SHALL have port: round_cnt  output  4  current round index, debug.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE: on in_valid && in_ready, SHALL load state <= plaintext ^ key_s1, set round_cnt <= 1, go to RUN. Otherwise SHALL hold.
REQ-015 RUN, round_cnt 1..9: each cycle SHALL compute state <= MixColumns(ShiftRows(SubBytes(state))) ^ key_s(round_cnt+1), then increment round_cnt.
REQ-016 RUN, round_cnt == 10: SHALL compute state <= ShiftRows(SubBytes(state)) ^ key_s11 with no MixColumns, then go to DONE.
REQ-017 SHALL implement exactly one round per cycle, using 16 combinational S-box lookups and GF(2^8) xtime with reduction polynomial 0x11B.
REQ-018 Latency: when a block is accepted at edge T, out_valid SHALL rise after edge T+10, with ciphertext valid in the same cycle.
REQ-019 DONE: ciphertext and out_valid SHALL hold stable while out_ready = 0.
REQ-020 DONE: on out_ready = 1, SHALL return to IDLE at that edge; out_valid SHALL drop and in_ready SHALL rise in the next cycle.
REQ-021 SHALL NOT accept a new block in the same cycle as the DONE handshake; minimum spacing between acceptances is 12 cycles.
REQ-022 in_valid and plaintext SHALL be ignored in RUN and DONE.
REQ-023 Round keys SHALL NOT be registered; the upstream driver shall hold key_s1..key_s11 stable from acceptance until out_valid. Key changes mid-operation produce undefined ciphertext but SHALL NOT affect FSM sequencing.
REQ-024 ciphertext SHALL be driven directly from the state register; its value outside DONE is don't-care to consumers.
REQ-025 round_cnt SHALL be 0 in IDLE, 1..10 in RUN, and 10 in DONE.

Reset
REQ-026 rst = 1 at a clock edge SHALL force IDLE, state = 0, round_cnt = 0, out_valid = 0, in_ready = 1 in the following cycle, regardless of current state.
REQ-027 Reset mid-RUN or in DONE SHALL discard the block with no output handshake.
REQ-028 rst SHALL take priority over all handshakes in the same cycle.

Verification
REQ-029 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f expanded by key_Expansion_128, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after acceptance.
REQ-030 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-031 Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> ciphertext and out_valid stable throughout; in_ready stays 0; a single handshake on out_ready = 1.
REQ-032 Back-to-back: keep in_valid = 1 continuously with out_ready = 1 and two blocks (C.1, then App. B) -> two correct results, 12 cycles apart; in_valid is ignored while busy.
REQ-033 Reset during RUN at round_cnt = 5 -> next cycle in IDLE, out_valid = 0, round_cnt = 0; a following C.1 block still yields 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Check round_cnt sequence 0,1..10,10,0 across one transaction, and in_ready/out_valid never both high.
